// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit R/W registers with byte strobes,
// one outstanding write and one outstanding read, out-of-range -> SLVERR.
module axi_lite_reg_slave #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              s_awaddr,
    input  logic [2:0]               s_awprot,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [31:0]              s_araddr,
    input  logic [2:0]               s_arprot,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    output logic [NUM_REGS*32-1:0]   regs_q,
    output logic                     dbg_w_state_o,
    output logic                     dbg_r_state_o
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_RESP } r_state_e;

    // Handshakes: a transfer happens on a posedge where valid and ready are both 1;
    // valid/payload never depend on ready, and every ready/valid here is a flop.
    w_state_e               w_state_q, w_state_d;
    r_state_e               r_state_q, r_state_d;
    logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [31:0]            aw_addr_q, aw_addr_d, w_data_q, w_data_d;
    logic [3:0]             w_strb_q, w_strb_d;
    logic                   awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]            rdata_q, rdata_d;
    logic [NUM_REGS*32-1:0] regs_d;
    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic [31:0]            wr_old, wr_word;
    logic                   aw_hs, w_hs, ar_hs;
    logic                   unused_prot;

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >> (IDX_W + 2)) == 32'd0;
    endfunction

    assign aw_hs = s_awvalid && awready_q;
    assign w_hs  = s_wvalid && wready_q;
    assign ar_hs = s_arvalid && arready_q;
    assign unused_prot = ^{s_awprot, s_arprot};

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        wr_idx    = '0;
        wr_old    = '0;
        wr_word   = '0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_awaddr;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    w_data_d = s_wdata;
                    w_strb_d = s_wstrb;
                end
                // Commit on the edge that completes the AW/W pair.
                if (aw_held_d && w_held_d) begin
                    wr_idx = aw_addr_d[IDX_W+1:2];
                    wr_old = regs_q[{wr_idx, 5'd0} +: 32];
                    for (int k = 0; k < 4; k++) begin
                        wr_word[k*8 +: 8] = w_strb_d[k] ? w_data_d[k*8 +: 8] : wr_old[k*8 +: 8];
                    end
                    if (in_range(aw_addr_d)) begin
                        regs_d[{wr_idx, 5'd0} +: 32] = wr_word;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rd_idx    = '0;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_idx = s_araddr[IDX_W+1:2];
                    // regs_q is the pre-write value when a write commits on this edge.
                    if (in_range(s_araddr)) begin
                        rdata_d = regs_q[{rd_idx, 5'd0} +: 32];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = 32'h0;
                        rresp_d = RESP_SLVERR;
                    end
                    rvalid_d  = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
            regs_q    <= {NUM_REGS{RESET_VAL}};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
        end
    end

    assign s_awready     = awready_q;
    assign s_wready      = wready_q;
    assign s_arready     = arready_q;
    assign s_bvalid      = bvalid_q;
    assign s_bresp       = bresp_q;
    assign s_rvalid      = rvalid_q;
    assign s_rresp       = rresp_q;
    assign s_rdata       = rdata_q;
    assign dbg_w_state_o = (w_state_q == W_RESP);
    assign dbg_r_state_o = (r_state_q == R_RESP);
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Bench for axi_lite_reg_slave: reference register model plus expected queues
// for B and R responses, one task per scenario.
module tb_axi_lite_reg_slave;
    localparam int unsigned NREG = 16;
    localparam logic [31:0] RV   = 32'h5A5A_0F0F;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [2:0]  s_awprot = '0, s_arprot = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_arvalid = 1'b0;
    logic        s_bready = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [NREG*32-1:0] regs_q;
    logic        dbg_w_state, dbg_r_state;

    logic [31:0] model [NREG];
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    int n_vec = 0;
    int n_err = 0;

    axi_lite_reg_slave #(.NUM_REGS(NREG), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_q(regs_q), .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = RV;
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        logic [31:0] w;
        if (a < NREG * 4) begin
            w = model[a[5:2]];
            for (int k = 0; k < 4; k++) if (s[k]) w[k*8 +: 8] = d[k*8 +: 8];
            model[a[5:2]] = w;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    function automatic logic [33:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        if (a < NREG * 4) begin
            w = model[a[5:2]];
            return {2'b00, w};
        end
        return {2'b10, 32'h0};
    endfunction

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        s_awaddr = a;
        s_awprot = 3'($urandom_range(0, 7));
        s_awvalid = 1'b1;
        while (s_awready !== 1'b1 && n < TMO) begin tick(); n++; end
        n_vec++;
        if (s_awready !== 1'b1) begin
            n_err++;
            $display("FAIL aw_accept: awready=%b required 1", s_awready);
        end
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_wdata = d;
        s_wstrb = s;
        s_wvalid = 1'b1;
        while (s_wready !== 1'b1 && n < TMO) begin tick(); n++; end
        n_vec++;
        if (s_wready !== 1'b1) begin
            n_err++;
            $display("FAIL w_accept: wready=%b required 1", s_wready);
        end
        tick();
        s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        s_araddr = a;
        s_arprot = 3'($urandom_range(0, 7));
        s_arvalid = 1'b1;
        while (s_arready !== 1'b1 && n < TMO) begin tick(); n++; end
        n_vec++;
        if (s_arready !== 1'b1) begin
            n_err++;
            $display("FAIL ar_accept: arready=%b required 1", s_arready);
        end
        tick();
        s_arvalid = 1'b0;
    endtask

    // ---------------- scoreboard collectors ----------------
    task automatic collect_b(input int stall);
        int n = 0;
        logic [1:0] exp;
        repeat (stall) tick();
        s_bready = 1'b1;
        while (s_bvalid !== 1'b1 && n < TMO) begin tick(); n++; end
        exp = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'bxx;
        n_vec++;
        if (s_bvalid !== 1'b1 || s_bresp !== exp) begin
            n_err++;
            $display("FAIL bresp: bvalid=%b bresp=%b required bvalid=1 bresp=%b", s_bvalid, s_bresp, exp);
        end
        tick();
        s_bready = 1'b0;
    endtask

    task automatic collect_r(input int stall);
        int n = 0;
        logic [33:0] exp;
        repeat (stall) tick();
        s_rready = 1'b1;
        while (s_rvalid !== 1'b1 && n < TMO) begin tick(); n++; end
        exp = (exp_r_q.size() > 0) ? exp_r_q.pop_front() : 34'hx;
        n_vec++;
        if (s_rvalid !== 1'b1 || {s_rresp, s_rdata} !== exp) begin
            n_err++;
            $display("FAIL rdata: rvalid=%b rresp=%b rdata=%h required rresp=%b rdata=%h",
                     s_rvalid, s_rresp, s_rdata, exp[33:32], exp[31:0]);
        end
        tick();
        s_rready = 1'b0;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        model_write(a, d, s, r);
        exp_b_q.push_back(r);
        fork
            send_aw(a);
            send_w(d, s);
        join
        collect_b(0);
    endtask

    task automatic read_txn(input logic [31:0] a);
        exp_r_q.push_back(model_read(a));
        send_ar(a);
        collect_r(0);
    endtask

    // Read expectation captured before the write updates the model: both hit the same edge.
    task automatic txn_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                            input logic [31:0] ra, input int bstall, input int rstall);
        logic [1:0] r;
        exp_r_q.push_back(model_read(ra));
        model_write(wa, wd, ws, r);
        exp_b_q.push_back(r);
        fork
            send_aw(wa);
            send_w(wd, ws);
            send_ar(ra);
        join
        fork
            collect_b(bstall);
            collect_r(rstall);
        join
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: aw/w/ar rdy=%b%b%b bv=%b rv=%b bresp=%b rresp=%b rdata=%h required all 0",
                     s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata);
        end
        n_vec++;
        if (regs_q !== model_flat()) begin
            n_err++;
            $display("FAIL reset_regs: regs_q=%h required %h", regs_q, model_flat());
        end
        rst_n = 1'b1;
        n_vec++;
        if ({s_awready, s_wready, s_arready} !== 3'b000) begin
            n_err++;
            $display("FAIL ready_before_edge: readys=%b required 000", {s_awready, s_wready, s_arready});
        end
        tick();
        n_vec++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            n_err++;
            $display("FAIL ready_after_edge: readys=%b required 111", {s_awready, s_wready, s_arready});
        end
    endtask

    task automatic test_full_write_read();
        logic [1:0] r;
        model_write(32'h04, 32'hDEADBEEF, 4'hF, r);
        exp_b_q.push_back(r);
        fork
            send_aw(32'h04);
            send_w(32'hDEADBEEF, 4'hF);
        join
        n_vec++;
        if (s_bvalid !== 1'b1) begin
            n_err++;
            $display("FAIL b_latency: bvalid=%b required 1 one cycle after AW/W", s_bvalid);
        end
        n_vec++;
        if (regs_q[63:32] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL regs_q_reg1: got %h required deadbeef", regs_q[63:32]);
        end
        collect_b(0);
        exp_r_q.push_back(model_read(32'h04));
        send_ar(32'h04);
        n_vec++;
        if (s_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL r_latency: rvalid=%b required 1 one cycle after AR", s_rvalid);
        end
        collect_r(0);
    endtask

    task automatic test_partial_write();
        write_txn(32'h04, 32'h12345678, 4'h3);
        n_vec++;
        if (regs_q[63:32] !== 32'hDEAD5678) begin
            n_err++;
            $display("FAIL partial_write: reg1=%h required dead5678", regs_q[63:32]);
        end
        read_txn(32'h04);
        write_txn(32'h07, 32'hA1B2C3D4, 4'hC);
        read_txn(32'h05);
    endtask

    task automatic test_out_of_range();
        write_txn(32'h40, 32'hFFFF_FFFF, 4'hF);
        n_vec++;
        if (regs_q !== model_flat()) begin
            n_err++;
            $display("FAIL oor_write_regs: regs_q=%h required %h", regs_q, model_flat());
        end
        read_txn(32'h40);
        read_txn(32'h8000_0004);
        write_txn(32'h0001_0008, 32'h0BAD_0BAD, 4'hF);
        read_txn(32'h3C);
    endtask

    task automatic test_skew_backpressure();
        logic [1:0] r;
        model_write(32'h0C, 32'hCAFEF00D, 4'hF, r);
        exp_b_q.push_back(r);
        s_wdata = 32'hCAFEF00D;
        s_wstrb = 4'hF;
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        n_vec++;
        if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin
            n_err++;
            $display("FAIL w_held: wready/awready/bvalid=%b required 010", {s_wready, s_awready, s_bvalid});
        end
        tick();
        tick();
        s_awaddr = 32'h0C;
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        n_vec++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b100) begin
            n_err++;
            $display("FAIL skew_commit: bvalid/awready/wready=%b required 100", {s_bvalid, s_awready, s_wready});
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if ({s_bvalid, s_bresp, s_awready, s_wready} !== {1'b1, r, 2'b00}) begin
                n_err++;
                $display("FAIL b_stall: bvalid=%b bresp=%b awready=%b wready=%b required 1 %b 0 0",
                         s_bvalid, s_bresp, s_awready, s_wready, r);
            end
            tick();
        end
        collect_b(0);
        n_vec++;
        if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin
            n_err++;
            $display("FAIL ready_return: bvalid/awready/wready=%b required 011", {s_bvalid, s_awready, s_wready});
        end
        read_txn(32'h0C);
    endtask

    task automatic test_collision();
        write_txn(32'h08, 32'h11111111, 4'hF);
        txn_pair(32'h08, 32'h22222222, 4'hF, 32'h08, 0, 0);
        read_txn(32'h08);
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa, ra;
        for (int i = 0; i < 12; i++) begin
            wa = 32'($urandom_range(0, 17)) << 2;
            ra = 32'($urandom_range(0, 17)) << 2;
            txn_pair(wa, $urandom, 4'($urandom_range(0, 15)), ra,
                     $urandom_range(0, 3), $urandom_range(0, 3));
        end
        n_vec++;
        if (regs_q !== model_flat()) begin
            n_err++;
            $display("FAIL b2b_regs: regs_q=%h required %h", regs_q, model_flat());
        end
    endtask

    task automatic test_reset_mid();
        fork
            send_aw(32'h10);
            send_w(32'h77778888, 4'hF);
            send_ar(32'h14);
        join
        n_vec++;
        if ({s_bvalid, s_rvalid} !== 2'b11) begin
            n_err++;
            $display("FAIL pre_reset_valids: bvalid/rvalid=%b required 11", {s_bvalid, s_rvalid});
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({s_bvalid, s_rvalid, s_awready, s_wready, s_arready} !== 5'b0) begin
            n_err++;
            $display("FAIL async_reset: bv/rv/awr/wr/arr=%b required 00000",
                     {s_bvalid, s_rvalid, s_awready, s_wready, s_arready});
        end
        model_reset();
        n_vec++;
        if (regs_q !== model_flat()) begin
            n_err++;
            $display("FAIL mid_reset_regs: regs_q=%h required %h", regs_q, model_flat());
        end
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NREG; i++) read_txn(32'(i * 4));
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_out_of_range();
        test_skew_backpressure();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        n_vec++;
        if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect: b=%0d r=%0d required 0 0", exp_b_q.size(), exp_r_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite responder that terminates the slave side of the AXI-Lite path, e.g. behind the registered AXI pass-through, and implements a bank of `NUM_REGS` 32-bit read/write registers. It accepts AW and W independently and applies byte strobes. Out-of-range accesses get an error response. It supports one outstanding write and one outstanding read; the two channels run concurrently and independently. Register contents are also exported as a flat bus for use by downstream logic.

## Interface
- `NUM_REGS`, 16, register count; power of two, 2..256; `IDX_W = log2(NUM_REGS)`.
- `RESET_VAL`, 32'h0, reset value of every register.

- `clk` input 1: sole clock, all logic on posedge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `s_awaddr` input 32: write address.
- `s_awprot` input 3: accepted, ignored.
- `s_awvalid` input 1, `s_awready` output 1: write address handshake.
- `s_wdata` input 32, `s_wstrb` input 4: write data and byte enables; bit k enables byte k.
- `s_wvalid` input 1, `s_wready` output 1: write data handshake.
- `s_bresp` output 2, `s_bvalid` output 1, `s_bready` input 1: write response.
- `s_araddr` input 32, `s_arprot` input 3 (ignored), `s_arvalid` input 1, `s_arready` output 1: read address.
- `s_rdata` output 32, `s_rresp` output 2, `s_rvalid` output 1, `s_rready` input 1: read data.
- `regs_q` output `NUM_REGS*32`: register i on bits [32i+31:32i].

## Operation
- Address decode:
  - Index = addr[IDX_W+1:2]; addr[1:0] are ignored.
  - In range: addr < `NUM_REGS*4` and all upper bits zero. Response OKAY (2'b00).
  - Otherwise: SLVERR (2'b10), no register change, rdata 0.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: `s_awready` = 1 while no AW is held; `s_wready` = 1 while no W is held.
  - A handshake on either channel captures that payload into its holding register and drops that channel's ready on the same edge.
  - On the edge where the second of AW/W is captured (both together is allowed): the register is committed, `s_bresp` is loaded, `s_bvalid` goes to 1, and the FSM moves to W_RESP.
  - Commit rule: per byte, new = strb ? wdata : old.
  - W_RESP: both readys are 0. `s_bvalid` and `s_bresp` hold until `s_bready`.
  - On the B handshake edge: `s_bvalid` goes to 0, holding registers clear, both readys go to 1, FSM returns to W_IDLE.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: `s_arready` = 1.
  - On the AR handshake edge: `s_rdata` and `s_rresp` are loaded from the decoded register, `s_rvalid` goes to 1, `s_arready` goes to 0, FSM moves to R_RESP.
  - R_RESP: data and response hold until `s_rready`. On the R handshake edge: `s_rvalid` goes to 0, `s_arready` goes to 1.
- Same-edge read and write commit to the same register: the read returns the pre-write value.
- `s_awprot`, `s_arprot` and unused `s_wstrb` combinations have no side effects.

## Timing
- All outputs are registered.
- Reset values:
  - readys, valids, resps, `s_rdata`: 0.
  - Every register: `RESET_VAL`.
  - Both FSMs: IDLE.
  - Readys rise on the first clock edge after `rst_n` deasserts.
- Write latency:
  - AW and W accepted at edge T: `s_bvalid` = 1 and the register updated after edge T; `regs_q` reflects the new value from T.
  - W at T, AW at T+n: commit and `s_bvalid` at T+n.
- Read latency: AR accepted at edge T gives `s_rvalid` = 1 after T.
- Back-to-back: min 2 cycles per transaction per channel. The ready is low in the response cycle and high again the cycle after the response handshake.
- Valid and payload are held stable until the handshake, regardless of backpressure duration.
- An AW or W offered while the other is already held is still accepted only if its own holder is empty. A second AW before the W arrives stalls (`s_awready` = 0).
- Reset mid-transaction: all pending transactions are dropped immediately (async). No response is issued. Registers return to `RESET_VAL`.

## Test plan
- Full write and read back:
  - Write 0x04 = 0xDEADBEEF with strb 0xF, AW and W in the same cycle. Required: `s_bvalid` the next cycle, bresp 00.
  - Read 0x04. Required: rdata 0xDEADBEEF, rresp 00; `regs_q`[63:32] = 0xDEADBEEF.
- Partial write: write 0x04 = 0x12345678 with strb 0x3 over 0xDEADBEEF. Required: readback 0xDEAD5678.
- Out of range:
  - Write 0x40 (NUM_REGS = 16). Required: bresp 10, `regs_q` unchanged.
  - Read 0x40. Required: rresp 10, rdata 0.
  - Read 0x8000_0004. Required: rresp 10.
- Skewed channels and backpressure:
  - W presented 3 cycles before AW. Required: `s_wready` drops after the W handshake, `s_bvalid` follows the AW handshake.
  - Hold `s_bready` = 0 for 5 cycles. Required: `s_bvalid` and bresp stable, `s_awready` and `s_wready` stay 0; readys return the cycle after `s_bready`.
- Same-edge collision: with reg 2 = 0x11111111, AR 0x08 and AW/W 0x08 = 0x22222222 on the same edge. Required: rdata 0x11111111; a subsequent read returns 0x22222222.
- Reset mid-transaction: assert `rst_n` = 0 while `s_bvalid` = 1 and `s_rvalid` = 1. Required: all valids drop immediately and all registers read `RESET_VAL` after release.
